if_id_buffer: RTL and testbench

IF_ID_BUFFER -- requirements
Module: if_id_buffer

---
 rtl/if_id_buffer.sv | 172 +++++++++++++++++
 tb/tb_if_id_buffer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/if_id_buffer.sv
// if_id_buffer: fetch-to-decode skid buffer.
// A fetch accepted in cycle N is tracked in a one-deep stage (s1) while the
// instruction RAM answers. Its {pc, inst} pair is written into a 2-entry FIFO
// in cycle N+1 and reaches decode in cycle N+2. The head is held in dedicated
// output registers, so there is no combinational path from the RAM read data
// to id_inst.
// Optional feature macro: IF_ID_MISALIGN_CHK_EN (adds id_misalign and
// substitutes NOP_INST for fetches whose PC is not word aligned).
module if_id_buffer #(
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] if_pc,
   input  logic        if_req,
   output logic        if_ready,
   input  logic [31:0] inst_ram_rdata,
   input  logic        flush,
   input  logic        id_ready,
`ifdef IF_ID_MISALIGN_CHK_EN
   output logic        id_misalign,
`endif
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_inst
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned CNT_W = 2;
   localparam int unsigned OCC_W = 3;

   // fetch stage tracking the outstanding RAM read
   logic            s1_valid_q, s1_valid_d;
   logic [XLEN-1:0] s1_pc_q, s1_pc_d;

   // FIFO storage and control
   logic [XLEN-1:0]  pc_mem_q   [DEPTH];
   logic [XLEN-1:0]  pc_mem_d   [DEPTH];
   logic [XLEN-1:0]  inst_mem_q [DEPTH];
   logic [XLEN-1:0]  inst_mem_d [DEPTH];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   // head output registers
   logic [XLEN-1:0] head_pc_q, head_pc_d;
   logic [XLEN-1:0] head_inst_q, head_inst_d;

`ifdef IF_ID_MISALIGN_CHK_EN
   logic mis_mem_q [DEPTH];
   logic mis_mem_d [DEPTH];
   logic head_mis_q, head_mis_d;
`endif

   logic             accept_c;
   logic             pop_c;
   logic [OCC_W-1:0] occ_c;
   logic [XLEN-1:0]  wr_inst_c;
   logic             s1_mis_c;

   // handshakes and the occupancy that decides whether a new fetch can fit
   always_comb begin
      id_valid = (count_q != CNT_W'(0)) && !flush;
      pop_c    = id_valid && id_ready;
      occ_c    = OCC_W'(count_q) + OCC_W'(s1_valid_q) - OCC_W'(pop_c);
      if_ready = !rst_n && !flush && (occ_c <= OCC_W'(1));
      accept_c = if_req && if_ready;
   end

   // instruction word written into the FIFO for the returning fetch
   always_comb begin
      s1_mis_c  = (s1_pc_q[1:0] != 2'b00);
`ifdef IF_ID_MISALIGN_CHK_EN
      wr_inst_c = s1_mis_c ? NOP_INST : inst_ram_rdata;
`else
      wr_inst_c = inst_ram_rdata;
`endif
   end

   // next state for fetch stage, FIFO and head registers; flush wins
   always_comb begin
      s1_valid_d  = accept_c;
      s1_pc_d     = accept_c ? if_pc : s1_pc_q;
      pc_mem_d    = pc_mem_q;
      inst_mem_d  = inst_mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      head_pc_d   = head_pc_q;
      head_inst_d = head_inst_q;
`ifdef IF_ID_MISALIGN_CHK_EN
      mis_mem_d   = mis_mem_q;
      head_mis_d  = head_mis_q;
`endif

      if (flush) begin
         s1_valid_d = 1'b0;
         wr_ptr_d   = 1'b0;
         rd_ptr_d   = 1'b0;
         count_d    = CNT_W'(0);
      end else begin
         if (s1_valid_q) begin
            pc_mem_d[wr_ptr_q]   = s1_pc_q;
            inst_mem_d[wr_ptr_q] = wr_inst_c;
`ifdef IF_ID_MISALIGN_CHK_EN
            mis_mem_d[wr_ptr_q]  = s1_mis_c;
`endif
            wr_ptr_d = ~wr_ptr_q;
         end
         if (pop_c) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         count_d = count_q + CNT_W'(s1_valid_q) - CNT_W'(pop_c);
         // head only moves when something will be there; otherwise it holds
         if (count_d != CNT_W'(0)) begin
            head_pc_d   = pc_mem_d[rd_ptr_d];
            head_inst_d = inst_mem_d[rd_ptr_d];
`ifdef IF_ID_MISALIGN_CHK_EN
            head_mis_d  = mis_mem_d[rd_ptr_d];
`endif
         end
      end
   end

   // state registers with synchronous active-high reset
   always_ff @(posedge clk) begin
      if (rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_pc_q     <= '0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         count_q     <= '0;
         head_pc_q   <= '0;
         head_inst_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]   <= '0;
            inst_mem_q[i] <= '0;
         end
`ifdef IF_ID_MISALIGN_CHK_EN
         head_mis_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mis_mem_q[i] <= 1'b0;
         end
`endif
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_pc_q     <= s1_pc_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         head_pc_q   <= head_pc_d;
         head_inst_q <= head_inst_d;
         pc_mem_q    <= pc_mem_d;
         inst_mem_q  <= inst_mem_d;
`ifdef IF_ID_MISALIGN_CHK_EN
         head_mis_q  <= head_mis_d;
         mis_mem_q   <= mis_mem_d;
`endif
      end
   end

   // head outputs straight from registers
   always_comb begin
      id_pc   = head_pc_q;
      id_inst = head_inst_q;
`ifdef IF_ID_MISALIGN_CHK_EN
      id_misalign = head_mis_q && id_valid;
`endif
   end

endmodule

// File: tb/tb_if_id_buffer.sv
// Scoreboard bench for if_id_buffer: accepted fetches are pushed with their
// expected {pc, inst} and compared as they reach the decode side.
module tb_if_id_buffer;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] if_pc;
   logic        if_req;
   logic        if_ready;
   logic [31:0] inst_ram_rdata;
   logic        flush;
   logic        id_ready;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
`ifdef IF_ID_MISALIGN_CHK_EN
   logic        id_misalign;
`endif

   if_id_buffer #(.NOP_INST(NOP)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .if_pc          (if_pc),
      .if_req         (if_req),
      .if_ready       (if_ready),
      .inst_ram_rdata (inst_ram_rdata),
      .flush          (flush),
      .id_ready       (id_ready),
`ifdef IF_ID_MISALIGN_CHK_EN
      .id_misalign    (id_misalign),
`endif
      .id_valid       (id_valid),
      .id_pc          (id_pc),
      .id_inst        (id_inst)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        mis;
   } ent_t;

   ent_t        sb_q[$];
   logic        m_s1;
   logic        m_init;
   logic        m_acc;
   logic [31:0] m_last_pc;
   logic [31:0] m_last_inst;
   logic [31:0] prev_pc;
   int          total;
   int          bad;

   function automatic logic [31:0] ram_of(input logic [31:0] a);
      return (a == 32'h0000_0102) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_0000);
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // one clock cycle: drive, check against the model, advance the model
   task automatic step(input logic req, input logic [31:0] pc, input logic idr,
                       input logic fl, input logic rs);
      int   cnt;
      logic ev;
      logic pop;
      logic er;
      ent_t e;
      if_req         = req;
      if_pc          = pc;
      id_ready       = idr;
      flush          = fl;
      rst_n          = rs;
      inst_ram_rdata = ram_of(prev_pc);
      #1;
      cnt = sb_q.size() - int'(m_s1);
      ev  = (cnt != 0) && !fl;
      pop = ev && idr;
      er  = !rs && !fl && ((cnt + int'(m_s1) - int'(pop)) <= 1);
      check_val("if_ready", 32'(if_ready), 32'(er));
      if (!rs && m_init) begin
         check_val("id_valid", 32'(id_valid), 32'(ev));
         if (ev) begin
            check_val("id_pc", id_pc, sb_q[0].pc);
            check_val("id_inst", id_inst, sb_q[0].inst);
`ifdef IF_ID_MISALIGN_CHK_EN
            check_val("id_misalign", 32'(id_misalign), 32'(sb_q[0].mis));
`endif
         end else begin
            check_val("hold_pc", id_pc, m_last_pc);
            check_val("hold_inst", id_inst, m_last_inst);
`ifdef IF_ID_MISALIGN_CHK_EN
            check_val("id_misalign_idle", 32'(id_misalign), 32'd0);
`endif
         end
      end
      m_acc = 1'b0;
      if (rs) begin
         sb_q.delete();
         m_s1        = 1'b0;
         m_init      = 1'b1;
         m_last_pc   = '0;
         m_last_inst = '0;
      end else if (fl) begin
         sb_q.delete();
         m_s1 = 1'b0;
      end else begin
         if (pop) void'(sb_q.pop_front());
         m_acc = req && er;
         if (m_acc) begin
            e.pc  = pc;
            e.mis = (pc[1:0] != 2'b00);
`ifdef IF_ID_MISALIGN_CHK_EN
            e.inst = e.mis ? NOP : ram_of(pc);
`else
            e.inst = ram_of(pc);
`endif
            sb_q.push_back(e);
         end
         m_s1 = m_acc;
         if ((sb_q.size() - int'(m_s1)) != 0) begin
            m_last_pc   = sb_q[0].pc;
            m_last_inst = sb_q[0].inst;
         end
      end
      prev_pc = pc;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] pc;
      total  = 0;
      bad    = 0;
      m_s1   = 1'b0;
      m_init = 1'b0;
      m_acc  = 1'b0;
      m_last_pc   = '0;
      m_last_inst = '0;
      prev_pc = '0;
      if_req = 1'b0; if_pc = '0; id_ready = 1'b0; flush = 1'b0; rst_n = 1'b1;
      inst_ram_rdata = '0;
      @(negedge clk);

      // reset
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

      // streaming, decode always ready
      for (int i = 0; i < 10; i++) step(1'b1, 32'(i * 4), 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

      // backpressure: decode stalls from cycle 3, fetch holds PC until accepted
      pc = 32'h0;
      for (int i = 0; i < 10; i++) begin
         step(1'b1, pc, (i < 3), 1'b0, 1'b0);
         if (m_acc) pc = pc + 32'd4;
      end
      // count=2, s1 idle: accept and pop in the same cycle
      step(1'b1, pc, 1'b1, 1'b0, 1'b0);
      if (m_acc) pc = pc + 32'd4;
      for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

      // flush with an entry buffered and a fetch in flight
      step(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h204, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h208, 1'b0, 1'b1, 1'b0);
      step(1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

      // reset mid-stream with the FIFO full
      step(1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h304, 1'b0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h308, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

      // misaligned and aligned fetch
      step(1'b1, 32'h102, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h104, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

      // random traffic
      pc = 32'h1000;
      for (int i = 0; i < 400; i++) begin
         logic [31:0] p;
         p = ($urandom_range(0, 7) == 0) ? (pc | 32'(($urandom_range(1, 3)))) : pc;
         step(($urandom_range(0, 3) != 0), p, ($urandom_range(0, 2) != 0),
              ($urandom_range(0, 24) == 0), ($urandom_range(0, 99) == 0));
         if (m_acc) pc = pc + 32'd4;
      end
      for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
